audio_capture_master: RTL and testbench

AUDIO_CAPTURE_MASTER -- requirements
Module: audio_capture_master

---
 rtl/audio_capture_master.sv | 189 ++++++++++++++++++
 tb/tb_audio_capture_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_capture_master.sv
// audio_capture_master: captures num_words stream samples into on-chip memory, then reads them back and sums them.
// Latency: one registered write per accepted sample, then one read per cycle; done 2 cycles after the last read issue.
// Backpressure: sample_ready drops outside WRITE or once the word count is reached; stalls forever on missing samples.
//
// Ports:
//   clk, reset              single rising-edge clock, synchronous active-high reset
//   start/base_addr/num_words  capture request and its parameters (sampled only in IDLE)
//   sample_data/_valid/_ready  input sample stream (valid/ready)
//   mem_*                   single-port memory master (readdata valid one cycle after the read address)
//   busy/done/checksum      status: busy through WRITE/READ/FLUSH, one-cycle done, 32-bit read-back sum
module audio_capture_master #(
    parameter int DEPTH = 100000,
    parameter int AW    = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] num_words,
    input  logic [31:0]   sample_data,
    input  logic          sample_valid,
    output logic          sample_ready,
    output logic [AW-1:0] mem_address,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [3:0]    mem_byteenable,
    output logic [31:0]   mem_writedata,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,
    output logic          busy,
    output logic          done,
    output logic [31:0]   checksum
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] DEPTH_W   = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] base_r;
    logic [AW-1:0] count_r;
    logic [AW-1:0] ptr;
    logic [AW-1:0] acc_cnt;
    logic [AW-1:0] rd_cnt;
    logic          rd_issued;    // mem outputs currently present a read
    logic          rd_data_vld;  // mem_readdata is valid this cycle

    logic [AW-1:0] count_clamped;
    logic [AW-1:0] ptr_inc;
    logic          write_open;
    logic          handshake;
    logic          last_write;
    logic          read_go;
    logic          last_read;

    assign mem_byteenable = 4'b1111;
    assign mem_clken      = 1'b1;

    assign count_clamped = (32'(num_words) > 32'(DEPTH)) ? DEPTH_W : num_words;

    // Pointer wraps at the memory depth, not at the address-width limit.
    assign ptr_inc = (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);

    assign write_open = (state == S_WRITE) && (acc_cnt < count_r);
    assign handshake  = write_open && sample_valid;
    assign last_write = handshake && ((acc_cnt + AW'(1)) == count_r);
    assign read_go    = (state == S_READ) && (rd_cnt < count_r);
    assign last_read  = read_go && ((rd_cnt + AW'(1)) == count_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sample_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_words == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                busy         = 1'b1;
                sample_ready = write_open;
                if (last_write) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (last_read) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Leave once the final read word is on mem_readdata and no read is still in flight.
                busy = 1'b1;
                if (rd_data_vld && !rd_issued) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_r         <= '0;
            count_r        <= '0;
            ptr            <= '0;
            acc_cnt        <= '0;
            rd_cnt         <= '0;
            rd_issued      <= 1'b0;
            rd_data_vld    <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            checksum       <= '0;
        end else begin
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            rd_issued      <= read_go;
            rd_data_vld    <= rd_issued;

            if (rd_data_vld) begin
                checksum <= checksum + mem_readdata;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_r   <= base_addr;
                        count_r  <= count_clamped;
                        ptr      <= base_addr;
                        acc_cnt  <= '0;
                        rd_cnt   <= '0;
                        checksum <= '0;
                    end
                end
                S_WRITE: begin
                    if (handshake) begin
                        mem_chipselect <= 1'b1;
                        mem_write      <= 1'b1;
                        mem_address    <= ptr;
                        mem_writedata  <= sample_data;
                        acc_cnt        <= acc_cnt + AW'(1);
                        // The read pass restarts from the latched base.
                        ptr            <= last_write ? base_r : ptr_inc;
                    end
                end
                S_READ: begin
                    if (read_go) begin
                        mem_chipselect <= 1'b1;
                        mem_write      <= 1'b0;
                        mem_address    <= ptr;
                        ptr            <= ptr_inc;
                        rd_cnt         <= rd_cnt + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_capture_master.sv
module tb_audio_capture_master;

    localparam int DEPTH = 24;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_words = '0;
    logic [31:0]   sample_data = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic [31:0]   mem_readdata = '0;
    logic          busy;
    logic          done;
    logic [31:0]   checksum;

    audio_capture_master #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .num_words(num_words),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .mem_address(mem_address),
        .mem_chipselect(mem_chipselect),
        .mem_write(mem_write),
        .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata),
        .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .busy(busy),
        .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Behavioural on-chip memory: read data appears the cycle after the address.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) mem[mem_address] <= mem_writedata;
            else           mem_readdata <= mem[mem_address];
        end
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   dat;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] ck_q[$];
    logic [31:0] smp[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic        hs_prev = 1'b0;
    logic        done_prev = 1'b0;
    txn_t        mt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT drives a memory access or done.
    always @(negedge clk) begin
        if (reset) begin
            hs_prev   = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (mem_chipselect) begin
                chk("busy_during_mem", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_mem_op: got access at 0x%0h, expected none", mem_address);
                end else begin
                    mt = exp_q.pop_front();
                    chk("mem_write", 32'(mem_write), 32'(mt.wr));
                    chk("mem_address", 32'(mem_address), 32'(mt.addr));
                    if (mt.wr) begin
                        chk("mem_writedata", mem_writedata, mt.dat);
                        chk("write_follows_handshake", 32'(hs_prev), 32'd1);
                    end
                end
            end
            if (done) begin
                if (ck_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    chk("checksum", checksum, ck_q.pop_front());
                end
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("ops_left_at_done", 32'(exp_q.size()), 32'd0);
                chk("done_one_cycle", 32'(done_prev), 32'd0);
                done_cnt++;
            end
            hs_prev   = sample_valid && sample_ready;
            done_prev = done;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sample_ready"}, 32'(sample_ready), 32'd0);
        chk({tag, "_chipselect"}, 32'(mem_chipselect), 32'd0);
        chk({tag, "_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_address"}, 32'(mem_address), 32'd0);
        chk({tag, "_writedata"}, mem_writedata, 32'd0);
        chk({tag, "_checksum"}, checksum, 32'd0);
        chk({tag, "_byteenable"}, 32'(mem_byteenable), 32'hF);
        chk({tag, "_clken"}, 32'(mem_clken), 32'd1);
    endtask

    task automatic fill_rand();
        smp.delete();
        for (int i = 0; i < 32; i++) smp.push_back($urandom());
    endtask

    // One capture: model expectations from the sample list, then drive the stream.
    task automatic capture(input logic [AW-1:0] b, input logic [AW-1:0] n, input bit use_pat,
                           input logic [7:0] vpat, input int gap_pct, input bit poke,
                           input bit rst_in_read);
        int          eff;
        int          idx;
        int          cyc;
        int          d0;
        logic [31:0] sum;
        txn_t        t;
        eff = (int'(n) > DEPTH) ? DEPTH : int'(n);
        sum = '0;
        for (int i = 0; i < eff; i++) begin
            t.wr = 1'b1; t.addr = AW'((int'(b) + i) % DEPTH); t.dat = smp[i];
            exp_q.push_back(t);
            sum += smp[i];
        end
        for (int i = 0; i < eff; i++) begin
            t.wr = 1'b0; t.addr = AW'((int'(b) + i) % DEPTH); t.dat = '0;
            exp_q.push_back(t);
        end
        ck_q.push_back(sum);
        d0 = done_cnt;

        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_words = n;
        @(posedge clk); #1;
        start = 1'b0;

        idx = 0;
        cyc = 0;
        while (idx < eff && cyc < 2000) begin
            sample_valid = use_pat ? vpat[cyc % 8] : ($urandom_range(99) >= gap_pct);
            sample_data  = sample_valid ? smp[idx] : $urandom();
            if (poke && cyc == 1) begin
                start = 1'b1; base_addr = ~b; num_words = AW'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (sample_valid && sample_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        sample_valid = 1'b0;
        start = 1'b0;
        if (idx < eff) begin
            n_chk++;
            n_fail++;
            $display("FAIL sample_timeout: got %0d samples accepted, expected %0d", idx, eff);
        end

        if (rst_in_read) begin
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_zero("reset_in_read");
            reset = 1'b0;
            exp_q.delete();
            void'(ck_q.pop_back());
            @(posedge clk); #1;
        end else begin
            cyc = 0;
            while (done_cnt == d0 && cyc < 300) begin
                @(posedge clk);
                cyc++;
            end
            #1;
            if (done_cnt == d0) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_timeout: got no done, expected one within 300 cycles");
                exp_q.delete();
                ck_q.delete();
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic capture 1,2,3,4 back to back -> checksum 10
        smp = '{32'd1, 32'd2, 32'd3, 32'd4};
        capture(AW'(5'h10), AW'(4), 1'b1, 8'hFF, 0, 1'b0, 1'b0);
        chk("idle_after_basic_busy", 32'(busy), 32'd0);

        // Wrap across the end of memory
        fill_rand();
        capture(AW'(DEPTH - 2), AW'(4), 1'b0, 8'h00, 0, 1'b0, 1'b0);

        // Zero length: straight to done, no memory access
        capture(AW'(9), AW'(0), 1'b1, 8'hFF, 0, 1'b0, 1'b0);

        // Checksum overflow wraps modulo 2^32
        smp = '{32'hFFFF_FFFF, 32'h0000_0002};
        capture(AW'(3), AW'(2), 1'b1, 8'hFF, 0, 1'b0, 1'b0);

        // Valid gaps 1,0,0,1 and a start pulse while writing
        fill_rand();
        capture(AW'(2), AW'(2), 1'b1, 8'b1111_1001, 0, 1'b1, 1'b0);

        // Oversized count is clamped to the memory depth
        fill_rand();
        capture(AW'(5), AW'(30), 1'b0, 8'h00, 20, 1'b0, 1'b0);

        // Reset during the read pass, then a normal capture
        fill_rand();
        capture(AW'(7), AW'(6), 1'b1, 8'hFF, 0, 1'b0, 1'b1);
        fill_rand();
        capture(AW'(20), AW'(5), 1'b0, 8'h00, 30, 1'b0, 1'b0);

        // Random captures
        for (int k = 0; k < 12; k++) begin
            fill_rand();
            capture(AW'($urandom_range(DEPTH - 1)), AW'($urandom_range(28)), 1'b0, 8'h00, 30,
                    1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
